counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Sequencing controller for the team's 4-bit counter datapath. It owns a synchronous WIDTH-bit up/down counter and runs it through a programmed job. A job loads a start value, counts a programmed number of wrap-arounds in the selected direction, then reports completion. Pause, abort and ripple-carry (RCO) outputs let the block act as the run/stop master for cascaded counter stages and timers built on the existing counters.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- WRAP_W, 4, width of wrap-count programming and status

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  job request; sampled only in IDLE
- stop  in  1  abort; returns to IDLE from LOAD, RUN or HOLD
- pause  in  1  level; freezes counting while high in RUN/HOLD
- up_dn  in  1  direction, 1 = up, 0 = down; latched at start
- load_val  in  WIDTH  initial count; latched at start
- wraps  in  WRAP_W  number of terminal crossings to run; 0 = free-run until stop; latched at start
- count  out  WIDTH  current counter value, registered
- rco  out  1  ripple-carry: high when count is all-ones or all-zeros, in any state
- wrap_cnt  out  WRAP_W  terminal crossings completed in the current job, registered
- busy  out  1  high in LOAD, RUN, HOLD, DONE
- done  out  1  high for exactly one cycle, while in DONE

## Operation
States: IDLE, LOAD, RUN, HOLD, DONE (registered FSM). The terminal value TERM is all-ones when counting up and zero when counting down.

- **IDLE**
  - count and wrap_cnt hold their values.
  - start=1 latches up_dn, load_val and wraps, then goes to LOAD.
- **LOAD** (one cycle)
  - count <= load_val_q, wrap_cnt <= 0, then goes to RUN.
- **RUN**, per edge:
  - count steps by ±1 modulo 2^WIDTH.
  - When count==TERM at the edge:
    - If wraps_q≠0 and wrap_cnt==wraps_q−1: go to DONE. count holds at TERM; wrap_cnt increments.
    - Otherwise: count wraps (15→0 up, 0→15 down for WIDTH=4); wrap_cnt increments modulo 2^WRAP_W. This also applies in free-run mode.
- **HOLD**
  - count and wrap_cnt are frozen.
  - pause=0 returns to RUN.
- **DONE** (one cycle)
  - done=1, then goes to IDLE. count keeps TERM and wrap_cnt keeps wraps_q.
- **Priority per edge:** stop > pause > step.
  - stop in LOAD, RUN or HOLD goes to IDLE. count and wrap_cnt keep their current values; no done pulse.
  - pause in RUN goes to HOLD; the step is suppressed on that edge.
  - stop in DONE is ignored.
- start while busy is ignored; nothing is queued.
- Inputs up_dn, load_val and wraps may change freely while busy without any effect.
- Arithmetic is unsigned modulo 2^WIDTH. No saturation anywhere.

## Timing
- Reset (asynchronous assert; release synchronised by the system) forces:
  - state=IDLE, count=0, wrap_cnt=0, busy=0, done=0
  - rco=1, because count=0
- rst_n low mid-job aborts immediately; no done is produced.
- Edge E0 samples start in IDLE:
  - after E0: busy=1, state LOAD
  - after E1: count=load_val
  - after E2: first step
- Job length, up direction, from load value L with W≥1 wraps:
  - DONE is entered at edge E1 + (2^WIDTH − 1 − L) + (W−1)·2^WIDTH + 1.
  - busy drops one edge after that.
- Down direction: replace (2^WIDTH − 1 − L) with L.
- Each HOLD cycle adds exactly one cycle to the job.
- rco is combinational from the count register. It has zero latency relative to count.

## Test plan
1. Reset: hold rst_n=0 with clock running, then release → count=0, wrap_cnt=0, busy=0, done=0, rco=1. Pulse rst_n low in mid-RUN → same values immediately, no done pulse.
2. Up, single wrap: load_val=13, up_dn=1, wraps=1, start at E0 →
   - after E1: count 13; after E2: 14; after E3: 15 (rco=1)
   - after E4: DONE, done=1, count 15, wrap_cnt 1
   - after E5: IDLE, busy=0
3. Up, two wraps: load_val=14, wraps=2 →
   - count 15 after E2; count 0 after E3 with wrap_cnt=1
   - count 15 after E18; done=1 after E19
4. Down, pause: load_val=2, up_dn=0, wraps=1, pause high for 3 cycles while count=1 →
   - count stays 1 for 3 cycles
   - then steps to 0, and DONE is entered one edge later
   - total job 3 cycles longer than the unpaused run
5. Abort and ignore: free-run (wraps=0) from 5 up; start re-asserted while busy has no effect. stop after count reaches 9 → IDLE, count holds 9, no done pulse. stop and pause asserted together → stop wins.
6. Free-run wrap rollover: wraps=0, WRAP_W=4, run 16 full wraps → wrap_cnt returns to 0; never enters DONE.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Run/stop sequencer for a WIDTH-bit up/down counter: loads a start value, counts a
// programmed number of terminal crossings, then pulses done. Exposes rco for cascading.
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              up_dn,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WRAP_W-1:0] wraps,
    output logic [WIDTH-1:0]  count,
    output logic              rco,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start; count and wrap_cnt hold
    // LOAD  | one cycle; count takes the latched load value
    // RUN   | stepping one per edge toward the terminal value
    // HOLD  | paused; count and wrap_cnt frozen
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  count_d, load_q, term, step_val;
    logic [WRAP_W-1:0] wrap_d, wraps_q;
    logic              up_q, latch, at_term, last_wrap;

    assign term      = {WIDTH{up_q}};
    assign step_val  = up_q ? count + WIDTH'(1) : count - WIDTH'(1);
    assign at_term   = (count == term);
    assign last_wrap = (wraps_q != '0) && (wrap_cnt == wraps_q - WRAP_W'(1));

    always_comb begin
        state_d = state;
        count_d = count;
        wrap_d  = wrap_cnt;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = load_q;
                    wrap_d  = '0;
                    state_d = S_RUN;
                end
            end
            // Releasing pause steps on the same edge so each HOLD cycle costs exactly one cycle.
            S_RUN, S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_RUN;
                    if (at_term) begin
                        wrap_d = wrap_cnt + WRAP_W'(1);
                        if (last_wrap) begin
                            state_d = S_DONE;
                        end else begin
                            count_d = step_val;
                        end
                    end else begin
                        count_d = step_val;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            wrap_cnt <= '0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            wrap_cnt <= wrap_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q    <= 1'b0;
            load_q  <= '0;
            wraps_q <= '0;
        end else if (latch) begin
            up_q    <= up_dn;
            load_q  <= load_val;
            wraps_q <= wraps;
        end
    end

    assign rco  = (count == '1) || (count == '0);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: vector table plus hand-written job sequences,
// expected values queued on drive and popped after each clock edge.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, pause, up_dn;
    logic [3:0] load_val, wraps;
    logic [3:0] count, wrap_cnt;
    logic       rco, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] count;
        logic [3:0] wrap;
        logic       busy;
        logic       done;
        logic       rco;
    } exp_t;

    typedef struct {
        logic       start, stop, pause, up_dn;
        logic [3:0] load_val, wraps;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    counter_seq_ctrl #(.WIDTH(4), .WRAP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .up_dn(up_dn), .load_val(load_val), .wraps(wraps), .count(count),
        .rco(rco), .wrap_cnt(wrap_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input int c, input int wc, input logic b, input logic d);
        exp_t r;
        r.count = 4'(c);
        r.wrap  = 4'(wc);
        r.busy  = b;
        r.done  = d;
        r.rco   = (r.count == 4'd0) || (r.count == 4'd15);
        return r;
    endfunction

    function automatic void add(input logic s, input logic st, input logic p, input logic ud,
                                input int lv, input int w, input exp_t e);
        vec_t v;
        v.start = s; v.stop = st; v.pause = p; v.up_dn = ud;
        v.load_val = 4'(lv); v.wraps = 4'(w); v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic compare(input string name);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = sb.pop_front();
        if (count !== e.count || wrap_cnt !== e.wrap || busy !== e.busy ||
            done !== e.done || rco !== e.rco) begin
            n_fail++;
            $display("FAIL %s: got count=%0d wrap=%0d busy=%b done=%b rco=%b, want count=%0d wrap=%0d busy=%b done=%b rco=%b",
                     name, count, wrap_cnt, busy, done, rco,
                     e.count, e.wrap, e.busy, e.done, e.rco);
        end
    endtask

    task automatic step(input logic s, input logic st, input logic p, input logic ud,
                        input logic [3:0] lv, input logic [3:0] w, input exp_t e,
                        input string name);
        start = s; stop = st; pause = p; up_dn = ud; load_val = lv; wraps = w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic idle_step(input exp_t e, input string name);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e, name);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        start = 0; stop = 0; pause = 0; up_dn = 0; load_val = 0; wraps = 0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(ex(0, 0, 0, 0));
        compare({name, "_held"});
        rst_n = 1'b1;
        idle_step(ex(0, 0, 0, 0), {name, "_released"});
    endtask

    initial begin
        // Test 2: up, single wrap, inputs changed while busy
        add(1, 0, 0, 1, 13, 1, ex(0, 0, 1, 0));
        add(0, 0, 0, 0, 3, 5, ex(13, 0, 1, 0));
        add(0, 0, 0, 0, 3, 5, ex(14, 0, 1, 0));
        add(0, 0, 0, 1, 0, 0, ex(15, 0, 1, 0));
        add(0, 0, 0, 1, 0, 0, ex(15, 1, 1, 1));
        add(0, 0, 0, 1, 0, 0, ex(15, 1, 0, 0));
        add(0, 0, 0, 1, 0, 0, ex(15, 1, 0, 0));
        // Test 5: free-run from 5, start ignored while busy, stop at 9
        add(1, 0, 0, 1, 5, 0, ex(15, 1, 1, 0));
        add(1, 0, 0, 0, 0, 1, ex(5, 0, 1, 0));
        add(1, 0, 0, 0, 0, 1, ex(6, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0, ex(7, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0, ex(8, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0, ex(9, 0, 1, 0));
        add(0, 1, 0, 0, 0, 0, ex(9, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, ex(9, 0, 0, 0));
        // stop and pause together in RUN: stop wins
        add(1, 0, 0, 0, 10, 3, ex(9, 0, 1, 0));
        add(0, 0, 0, 1, 0, 0, ex(10, 0, 1, 0));
        add(0, 0, 0, 1, 0, 0, ex(9, 0, 1, 0));
        add(0, 1, 1, 0, 0, 0, ex(9, 0, 0, 0));
        add(0, 0, 1, 0, 0, 0, ex(9, 0, 0, 0));
        // stop while in HOLD
        add(1, 0, 0, 1, 0, 1, ex(9, 0, 1, 0));
        add(0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0));
        add(0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0));
        add(0, 1, 1, 1, 0, 1, ex(0, 0, 0, 0));
        // stop while in LOAD: load value never reaches count
        add(1, 0, 0, 1, 7, 1, ex(0, 0, 1, 0));
        add(0, 1, 0, 1, 7, 1, ex(0, 0, 0, 0));
        // down from 0 with one wrap: DONE straight after LOAD; stop in DONE ignored
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 1, 0));
        add(0, 0, 0, 0, 0, 1, ex(0, 0, 1, 0));
        add(0, 0, 0, 0, 0, 1, ex(0, 1, 1, 1));
        add(0, 1, 0, 0, 0, 1, ex(0, 1, 0, 0));

        do_reset("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].up_dn,
                 tbl[i].load_val, tbl[i].wraps, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Test 3: up, two wraps from 14
        do_reset("reset_t3");
        step(1, 0, 0, 1, 4'd14, 4'd2, ex(0, 0, 1, 0), "t3_e0");
        for (int k = 1; k <= 18; k++) begin
            idle_step(ex((13 + k) % 16, (k >= 3) ? 1 : 0, 1, 0), $sformatf("t3_e%0d", k));
        end
        idle_step(ex(15, 2, 1, 1), "t3_done");
        idle_step(ex(15, 2, 0, 0), "t3_idle");

        // Test 4: down from 2, pause for 3 cycles at count 1
        do_reset("reset_t4");
        step(1, 0, 0, 0, 4'd2, 4'd1, ex(0, 0, 1, 0), "t4_e0");
        idle_step(ex(2, 0, 1, 0), "t4_load");
        idle_step(ex(1, 0, 1, 0), "t4_e2");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1, 4'd9, 4'd9, ex(1, 0, 1, 0), $sformatf("t4_hold%0d", k));
        end
        idle_step(ex(0, 0, 1, 0), "t4_resume");
        idle_step(ex(0, 1, 1, 1), "t4_done");
        idle_step(ex(0, 1, 0, 0), "t4_idle");

        // Async reset in the middle of a run
        do_reset("reset_mid");
        step(1, 0, 0, 1, 4'd3, 4'd2, ex(0, 0, 1, 0), "mid_e0");
        idle_step(ex(3, 0, 1, 0), "mid_load");
        idle_step(ex(4, 0, 1, 0), "mid_run");
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(ex(0, 0, 0, 0));
        compare("mid_async_rst");
        for (int k = 0; k < 2; k++) begin
            sb.push_back(ex(0, 0, 0, 0));
            @(posedge clk);
            #1;
            compare($sformatf("mid_rst_hold%0d", k));
        end
        rst_n = 1'b1;
        idle_step(ex(0, 0, 0, 0), "mid_released");

        // Test 6: free-run, 16 full wraps roll wrap_cnt back to 0
        step(1, 0, 0, 1, 4'd0, 4'd0, ex(0, 0, 1, 0), "t6_e0");
        idle_step(ex(0, 0, 1, 0), "t6_load");
        for (int k = 2; k <= 257; k++) begin
            idle_step(ex((k - 1) % 16, ((k - 1) / 16) % 16, 1, 0), $sformatf("t6_e%0d", k));
        end
        step(0, 1, 0, 0, 4'd0, 4'd0, ex(0, 0, 0, 0), "t6_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks done", n_chk);
        $fatal(1, "timeout");
    end

endmodule
